// File: rtl/sequenciador_notas.sv
// Note sequencer: plays NUM_PASSOS slots {TOM, NOTA, DUR}, each held DUR+1 cycles
// followed by a one-cycle silent gap, with optional looping and Fim on completion.
module sequenciador_notas #(
  parameter int unsigned NUM_PASSOS = 8,
  parameter int unsigned DUR_W      = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Stop,
  input  logic                          Loop,
  input  logic                          Wr_en,
  input  logic [$clog2(NUM_PASSOS)-1:0] Wr_addr,
  input  logic [DUR_W+3:0]              Wr_data,
  output logic                          TOM_out,
  output logic [2:0]                    NOTAS,
  output logic                          Nota_valida,
  output logic                          Ocupado,
  output logic [$clog2(NUM_PASSOS)-1:0] Passo,
  output logic                          Fim
);

  localparam int unsigned PW = $clog2(NUM_PASSOS);
  localparam int unsigned SW = DUR_W + 4;

  typedef enum logic [1:0] {StOcioso, StTocando, StPausa} estado_e;

  estado_e          estado_q;
  logic [DUR_W-1:0] dur_q;
  logic [SW-1:0]    slots_q [NUM_PASSOS];

  logic [PW-1:0] passo_prox;
  logic [PW-1:0] idx_carga;
  logic [SW-1:0] slot_carga;
  logic          ultimo;

  // The slot to load is slot 0 when starting, otherwise the step after the current one.
  always_comb begin
    ultimo     = (Passo == PW'(NUM_PASSOS - 1));
    passo_prox = Passo + PW'(1);
    idx_carga  = (estado_q == StOcioso) ? '0 : passo_prox;
    slot_carga = slots_q[idx_carga];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_PASSOS); i++) begin
        slots_q[i] <= '0;
      end
    end else if (Wr_en && !Ocupado) begin
      slots_q[Wr_addr] <= Wr_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q    <= StOcioso;
      dur_q       <= '0;
      Passo       <= '0;
      TOM_out     <= 1'b0;
      NOTAS       <= 3'd0;
      Nota_valida <= 1'b0;
      Ocupado     <= 1'b0;
      Fim         <= 1'b0;
    end else begin
      Fim <= 1'b0;
      if (Stop) begin
        estado_q    <= StOcioso;
        dur_q       <= '0;
        Passo       <= '0;
        TOM_out     <= 1'b0;
        NOTAS       <= 3'd0;
        Nota_valida <= 1'b0;
        Ocupado     <= 1'b0;
      end else begin
        unique case (estado_q)
          StOcioso: begin
            if (Start) begin
              estado_q    <= StTocando;
              Passo       <= '0;
              TOM_out     <= slot_carga[SW-1];
              NOTAS       <= slot_carga[SW-2 -: 3];
              dur_q       <= slot_carga[DUR_W-1:0];
              Nota_valida <= 1'b1;
              Ocupado     <= 1'b1;
            end
          end
          StTocando: begin
            if (dur_q == '0) begin
              estado_q    <= StPausa;
              TOM_out     <= 1'b0;
              NOTAS       <= 3'd0;
              Nota_valida <= 1'b0;
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end
          StPausa: begin
            // passo_prox wraps to 0 naturally after the last step
            if (!ultimo || Loop) begin
              estado_q    <= StTocando;
              Passo       <= passo_prox;
              TOM_out     <= slot_carga[SW-1];
              NOTAS       <= slot_carga[SW-2 -: 3];
              dur_q       <= slot_carga[DUR_W-1:0];
              Nota_valida <= 1'b1;
            end else begin
              estado_q <= StOcioso;
              Passo    <= '0;
              Ocupado  <= 1'b0;
              Fim      <= 1'b1;
            end
          end
          default: estado_q <= StOcioso;
        endcase
      end
    end
  end

endmodule

// File: doc/sequenciador_notas.md
SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

Interface
REQ-001 SHALL have parameter NUM_PASSOS, default 8, meaning the number of note slots in the sequence (power of 2, 2..16).
REQ-002 SHALL have parameter DUR_W, default 4, meaning the width of the per-note duration field.
REQ-003 SHALL have port Clock  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  meaning a request to begin playback from step 0.
REQ-006 SHALL have port Stop  input  1  meaning abort playback immediately.
REQ-007 SHALL have port Loop  input  1  meaning wrap to step 0 instead of finishing; sampled at each last-step boundary.
REQ-008 SHALL have port Wr_en  input  1  meaning a write strobe for the slot memory.
REQ-009 SHALL have port Wr_addr  input  log2(NUM_PASSOS)  meaning the slot index to write.
REQ-010 SHALL have port Wr_data  input  4+DUR_W  meaning {TOM, NOTA[2:0], DUR[DUR_W-1:0]}.
REQ-011 SHALL have port TOM_out  output  1  meaning the tone bit driven to the display module.
REQ-012 SHALL have port NOTAS  output  3  meaning the note code driven to the display module.
REQ-013 SHALL have port Nota_valida  output  1  meaning TOM_out/NOTAS carry a note being played.
REQ-014 SHALL have port Ocupado  output  1  meaning playback is in progress.
REQ-015 SHALL have port Passo  output  log2(NUM_PASSOS)  meaning the index of the current step.
REQ-016 SHALL have port Fim  output  1  meaning a one-cycle pulse on normal completion of playback.

Function
REQ-017 SHALL hold NUM_PASSOS slots of 4+DUR_W bits; a write occurs on a Clock edge with Wr_en=1 only when Ocupado=0; writes while Ocupado=1 SHALL be ignored.
REQ-018 SHALL implement states OCIOSO, TOCANDO and PAUSA; all outputs SHALL be registered.
REQ-019 OCIOSO->TOCANDO SHALL occur on the edge sampling Start=1 and Stop=0; on that same edge Passo=0, TOM_out/NOTAS=slot 0, Nota_valida=1, Ocupado=1, and the duration counter SHALL load DUR of slot 0.
REQ-020 In TOCANDO the step SHALL be held for DUR+1 cycles: DUR=0 gives 1 cycle, DUR=2^DUR_W-1 gives 2^DUR_W cycles, and the counter SHALL decrement once per cycle.
REQ-021 When the counter reaches 0 in TOCANDO, the next edge SHALL enter PAUSA for exactly 1 cycle with Nota_valida=0 and TOM_out=0, NOTAS=0, Ocupado=1.
REQ-022 From PAUSA with Passo<NUM_PASSOS-1, the next edge SHALL enter TOCANDO with Passo+1 and load that slot.
REQ-023 From PAUSA with Passo=NUM_PASSOS-1 and Loop=1, the next edge SHALL wrap Passo to 0 and enter TOCANDO with no Fim pulse.
REQ-024 From PAUSA with Passo=NUM_PASSOS-1 and Loop=0, the next edge SHALL enter OCIOSO, assert Fim=1 for exactly that one cycle, and drive Ocupado=0 and Passo=0.
REQ-025 Stop=1 in any state SHALL force OCIOSO on the next edge with Nota_valida=0, Ocupado=0, Passo=0 and no Fim pulse; Stop SHALL win over a simultaneous Start.
REQ-026 Start while Ocupado=1 SHALL be ignored; no restart occurs.
REQ-027 A slot being played SHALL be latched at load, so its outputs stay constant for the step's full duration.

Reset
REQ-028 On Reset=0, asynchronously: state=OCIOSO, Passo=0, TOM_out=0, NOTAS=0, Nota_valida=0, Ocupado=0, Fim=0, duration counter=0, all slots=0.
REQ-029 Reset asserted mid-playback SHALL abort it with no Fim pulse; after release the block SHALL await Start.

Verification
REQ-030 Write slots 0..7 = {0,k,DUR=1}, Loop=0, pulse Start -> NOTAS steps 0..7, each valid 2 cycles with a 1-cycle gap, Fim high 1 cycle 24 cycles after Start, Ocupado low after.
REQ-031 Slot 3 DUR=0 and slot 4 DUR=15 -> step 3 valid 1 cycle, step 4 valid 16 cycles.
REQ-032 Loop=1 -> Passo wraps 7->0 with no Fim pulse; drop Loop during step 5 -> Fim pulses after step 7.
REQ-033 Stop at step 2 together with Start -> OCIOSO next edge, Fim stays 0, Nota_valida=0.
REQ-034 Wr_en to slot 0 during playback -> slot unchanged on the next pass; Start during playback -> Passo unaffected.
REQ-035 Reset=0 asynchronously mid-step 4 -> all outputs 0 before the next edge, and slots read back as 0 on the next playback.
